// File: rtl/link_pkg.sv
// Shared definitions for the single-wire state-exchange link (initiator and responder).
// Holds the FSM state encoding, line level constants and the even-parity helper.
package link_pkg;

    // Line levels: the pull-up holds the wire at the idle level between frames.
    localparam logic LINK_IDLE_LVL  = 1'b1;
    localparam logic LINK_START_LVL = 1'b0;
    localparam logic LINK_STOP_LVL  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_DATA,
        ST_RX_PAR,
        ST_TURN,
        ST_TX_START,
        ST_TX_DATA,
        ST_TX_PAR,
        ST_TX_STOP
    } link_state_t;

    // Even parity over the low nbits of data: the parity bit is the XOR of the data bits.
    function automatic logic link_parity(input logic [31:0] data, input int unsigned nbits);
        logic [31:0] mask;
        mask = (nbits >= 32) ? '1 : ((32'(1) << nbits) - 32'(1));
        return ^(data & mask);
    endfunction

endpackage

// File: rtl/link_pad.sv
// Tristate pad for the shared link wire.
// Ports: oe (drive enable), dout (level to drive), din (sampled line), data_link (wire).
module link_pad (
    input  logic oe,
    input  logic dout,
    output logic din,
    inout  wire  data_link
);

    assign data_link = oe ? dout : 1'bz;
    assign din       = data_link;

endmodule

// File: rtl/link_responder.sv
// Responder end of the half-duplex state-exchange link: receives an initiator frame,
// parity-checks it, turns the line around and replies with the local state.
// Ports: clk (link clock), Locked (sync active-low reset), my_state_in (reply payload),
// partner_state_out (last good received state), frame_ok / parity_err (one-cycle pulses),
// busy (FSM not idle), data_link (shared wire, externally pulled up).
module link_responder
    import link_pkg::*;
#(
    parameter int unsigned DATA_BITS = 1
) (
    input  logic                 clk,
    input  logic                 Locked,
    input  logic [DATA_BITS-1:0] my_state_in,
    output logic [DATA_BITS-1:0] partner_state_out,
    output logic                 frame_ok,
    output logic                 parity_err,
    output logic                 busy,
    inout  wire                  data_link
);

    localparam int unsigned   CNT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    link_state_t          state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] rx_shift;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;
    logic                 tx_oe;
    logic                 tx_dout;
    logic                 line_din;

    link_pad u_pad (
        .oe        (tx_oe),
        .dout      (tx_dout),
        .din       (line_din),
        .data_link (data_link)
    );

    // Link FSM: every line-facing and status output is a register.
    always_ff @(posedge clk) begin
        if (!Locked) begin
            state             <= ST_IDLE;
            bit_cnt           <= '0;
            rx_shift          <= '0;
            tx_shift          <= '0;
            tx_par            <= 1'b0;
            tx_oe             <= 1'b0;
            tx_dout           <= LINK_IDLE_LVL;
            partner_state_out <= '0;
            frame_ok          <= 1'b0;
            parity_err        <= 1'b0;
            busy              <= 1'b0;
        end else begin
            frame_ok   <= 1'b0;
            parity_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // An X/Z line compares unknown and is not taken as a start bit.
                    if (line_din == LINK_START_LVL) begin
                        state   <= ST_RX_DATA;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                ST_RX_DATA: begin
                    rx_shift[bit_cnt] <= line_din;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt <= '0;
                        state   <= ST_RX_PAR;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ST_RX_PAR: begin
                    if (line_din == link_parity(32'(rx_shift), DATA_BITS)) begin
                        partner_state_out <= rx_shift;
                        frame_ok          <= 1'b1;
                        state             <= ST_TURN;
                    end else begin
                        parity_err <= 1'b1;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                ST_TURN: begin
                    // Line stays released this cycle; the reply payload is frozen here.
                    tx_shift <= my_state_in;
                    tx_par   <= link_parity(32'(my_state_in), DATA_BITS);
                    tx_oe    <= 1'b1;
                    tx_dout  <= LINK_START_LVL;
                    state    <= ST_TX_START;
                end
                ST_TX_START: begin
                    tx_dout  <= tx_shift[0];
                    tx_shift <= tx_shift >> 1;
                    bit_cnt  <= '0;
                    state    <= ST_TX_DATA;
                end
                ST_TX_DATA: begin
                    if (bit_cnt == LAST_BIT) begin
                        tx_dout <= tx_par;
                        bit_cnt <= '0;
                        state   <= ST_TX_PAR;
                    end else begin
                        tx_dout  <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        bit_cnt  <= bit_cnt + 1'b1;
                    end
                end
                ST_TX_PAR: begin
                    tx_dout <= LINK_STOP_LVL;
                    state   <= ST_TX_STOP;
                end
                ST_TX_STOP: begin
                    tx_oe   <= 1'b0;
                    tx_dout <= LINK_IDLE_LVL;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    tx_oe <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
